dwt_decomp_stage: RTL and testbench

- Parametrised single-level DWT analysis stage for the feature-extraction chain.
- Runs an N-tap lowpass (approximation) and N-tap highpass (detail) FIR on a Q2.29 sample stream and decimates by 2, producing one approx/detail pair per two accepted samples.
- Coefficients are runtime-programmable; reset values implement Haar.
- Adds valid/ready handshaking, rounding, saturation and a sticky overflow flag. Sits between the preprocessing front end and the feature calculators; instances can be cascaded for multi-level decomposition.

---
 rtl/dwt_decomp_stage.sv | 193 +++++++++++++++++++
 tb/tb_dwt_decomp_stage.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwt_decomp_stage.sv
// Single-level DWT analysis stage: lowpass/highpass FIR pair, decimate by 2,
// rounded and saturated outputs behind a valid/ready register slice.
module dwt_decomp_stage #(
   parameter int DATA_W    = 32,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 13,
   parameter int TAPS      = 2,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_approx,
   output logic [DATA_W-1:0] out_detail,
   input  logic              coef_we,
   input  logic              coef_bank,
   input  logic [ADDR_W-1:0] coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic              sat_flag
);

   localparam int LOG_T  = $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + LOG_T;
   localparam int HIST_N = TAPS - 1;

   localparam logic [COEF_W-1:0] HAAR_P = COEF_W'(5793);
   localparam logic [COEF_W-1:0] HAAR_N = COEF_W'(-5793);
   localparam logic [ACC_W-1:0]  RND    = ACC_W'(1) << (COEF_FRAC - 1);

   logic [DATA_W-1:0] hist_q [HIST_N];
   logic [DATA_W-1:0] hist_d [HIST_N];
   logic [COEF_W-1:0] lo_q [TAPS];
   logic [COEF_W-1:0] lo_d [TAPS];
   logic [COEF_W-1:0] hi_q [TAPS];
   logic [COEF_W-1:0] hi_d [TAPS];

   logic              phase_q, phase_d;
   logic              out_valid_q, out_valid_d;
   logic              sat_q, sat_d;
   logic [DATA_W-1:0] approx_q, approx_d;
   logic [DATA_W-1:0] detail_q, detail_d;

   logic              accept, load, fire;
   logic [TAPS-1:0][DATA_W-1:0] win;
   logic [TAPS-1:0][ACC_W-1:0]  lo_term, hi_term;
   logic [ACC_W-1:0]  acc_lo, acc_hi;
   logic [DATA_W-1:0] res_lo, res_hi;
   logic              sat_lo, sat_hi;

   // Round half up, shift down to the sample scale, clamp; MSB of result flags a clamp.
   function automatic logic [DATA_W:0] round_sat(input logic [ACC_W-1:0] acc);
      logic [ACC_W-1:0]      r;
      logic [ACC_W-1:0]      s;
      logic [ACC_W-DATA_W:0] top;
      r   = acc + RND;
      s   = $signed(r) >>> COEF_FRAC;
      top = s[ACC_W-1:DATA_W-1];
      if ((&top) | ~(|top)) begin
         return {1'b0, s[DATA_W-1:0]};
      end else if (s[ACC_W-1]) begin
         return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
      end
   endfunction

   assign in_ready = ~phase_q | ~out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;
   assign load     = accept & phase_q;
   assign fire     = out_valid_q & out_ready;

   // Window includes the sample being accepted this cycle (tap 0 = newest).
   always_comb begin
      win[0] = in_data;
      for (int k = 1; k < TAPS; k++) begin
         win[k] = hist_q[k-1];
      end
   end

   generate
      for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
         logic [PROD_W-1:0] lo_p;
         logic [PROD_W-1:0] hi_p;
         assign lo_p = {{COEF_W{win[gi][DATA_W-1]}}, win[gi]}
                     * {{DATA_W{lo_q[gi][COEF_W-1]}}, lo_q[gi]};
         assign hi_p = {{COEF_W{win[gi][DATA_W-1]}}, win[gi]}
                     * {{DATA_W{hi_q[gi][COEF_W-1]}}, hi_q[gi]};
         assign lo_term[gi] = {{LOG_T{lo_p[PROD_W-1]}}, lo_p};
         assign hi_term[gi] = {{LOG_T{hi_p[PROD_W-1]}}, hi_p};
      end
   endgenerate

   always_comb begin
      acc_lo = '0;
      acc_hi = '0;
      for (int k = 0; k < TAPS; k++) begin
         acc_lo = acc_lo + lo_term[k];
         acc_hi = acc_hi + hi_term[k];
      end
   end

   assign {sat_lo, res_lo} = round_sat(acc_lo);
   assign {sat_hi, res_hi} = round_sat(acc_hi);

   always_comb begin
      hist_d      = hist_q;
      phase_d     = phase_q;
      out_valid_d = out_valid_q;
      approx_d    = approx_q;
      detail_d    = detail_q;
      sat_d       = sat_q;
      if (clr) begin
         for (int k = 0; k < HIST_N; k++) begin
            hist_d[k] = '0;
         end
         phase_d     = 1'b0;
         out_valid_d = 1'b0;
         approx_d    = '0;
         detail_d    = '0;
         sat_d       = 1'b0;
      end else begin
         if (accept) begin
            hist_d[0] = in_data;
            for (int k = 1; k < HIST_N; k++) begin
               hist_d[k] = hist_q[k-1];
            end
            phase_d = ~phase_q;
         end
         // A load in the same cycle as a handshake keeps the slot full.
         if (load) begin
            out_valid_d = 1'b1;
            approx_d    = res_lo;
            detail_d    = res_hi;
            sat_d       = sat_q | sat_lo | sat_hi;
         end else if (fire) begin
            out_valid_d = 1'b0;
         end
      end
   end

   // Coefficient writes take effect at the edge, so a coincident load sees the old tap.
   always_comb begin
      lo_d = lo_q;
      hi_d = hi_q;
      for (int k = 0; k < TAPS; k++) begin
         if (coef_we && (coef_addr == ADDR_W'(k))) begin
            if (coef_bank) begin
               hi_d[k] = coef_data;
            end else begin
               lo_d[k] = coef_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < HIST_N; k++) begin
            hist_q[k] <= '0;
         end
         for (int k = 0; k < TAPS; k++) begin
            lo_q[k] <= (k < 2) ? HAAR_P : '0;
            hi_q[k] <= (k == 0) ? HAAR_P : ((k == 1) ? HAAR_N : '0);
         end
         phase_q     <= 1'b0;
         out_valid_q <= 1'b0;
         approx_q    <= '0;
         detail_q    <= '0;
         sat_q       <= 1'b0;
      end else begin
         hist_q      <= hist_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         phase_q     <= phase_d;
         out_valid_q <= out_valid_d;
         approx_q    <= approx_d;
         detail_q    <= detail_d;
         sat_q       <= sat_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_approx = approx_q;
   assign out_detail = detail_q;
   assign sat_flag   = sat_q;

endmodule

// File: tb/tb_dwt_decomp_stage.sv
// Bench for dwt_decomp_stage (TAPS = 4 build): directed scenarios plus a
// randomized stream scored against an arithmetic window model.
module tb_dwt_decomp_stage;

   localparam int DATA_W    = 32;
   localparam int COEF_W    = 16;
   localparam int COEF_FRAC = 13;
   localparam int TAPS      = 4;
   localparam int ADDR_W    = 4;
   localparam longint MAXV  = 64'sd2147483647;
   localparam longint MINV  = -64'sd2147483648;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_approx;
   logic [DATA_W-1:0] out_detail;
   logic              coef_we = 1'b0;
   logic              coef_bank = 1'b0;
   logic [ADDR_W-1:0] coef_addr = '0;
   logic [COEF_W-1:0] coef_data = '0;
   logic              sat_flag;

   int vectors = 0;
   int miscompares = 0;

   longint m_lo [TAPS];
   longint m_hi [TAPS];
   longint m_win [TAPS];
   int     m_cnt;
   bit     m_sat;
   longint exp_a [$];
   longint exp_d [$];
   bit     exp_s [$];

   dwt_decomp_stage #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .TAPS(TAPS), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_approx(out_approx), .out_detail(out_detail),
      .coef_we(coef_we), .coef_bank(coef_bank), .coef_addr(coef_addr), .coef_data(coef_data),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   task automatic model_haar();
      for (int k = 0; k < TAPS; k++) begin
         m_lo[k] = 0;
         m_hi[k] = 0;
      end
      m_lo[0] = 5793; m_lo[1] = 5793;
      m_hi[0] = 5793; m_hi[1] = -5793;
   endtask

   task automatic model_clear();
      for (int k = 0; k < TAPS; k++) m_win[k] = 0;
      m_cnt = 0;
      m_sat = 0;
      exp_a.delete();
      exp_d.delete();
      exp_s.delete();
   endtask

   task automatic model_accept(input logic [DATA_W-1:0] d);
      longint sa, sd, ra, rd;
      for (int k = TAPS - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = longint'($signed(d));
      m_cnt++;
      if (m_cnt % 2 == 0) begin
         sa = 0;
         sd = 0;
         for (int k = 0; k < TAPS; k++) begin
            sa += m_win[k] * m_lo[k];
            sd += m_win[k] * m_hi[k];
         end
         ra = (sa + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
         rd = (sd + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
         if (ra > MAXV) begin ra = MAXV; m_sat = 1; end
         if (ra < MINV) begin ra = MINV; m_sat = 1; end
         if (rd > MAXV) begin rd = MAXV; m_sat = 1; end
         if (rd < MINV) begin rd = MINV; m_sat = 1; end
         exp_a.push_back(ra);
         exp_d.push_back(rd);
         exp_s.push_back(m_sat);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                       input logic we, input logic bank, input logic [ADDR_W-1:0] addr,
                       input logic [COEF_W-1:0] cd,
                       output logic acc, output logic fire, output logic ov,
                       output logic [DATA_W-1:0] oa, output logic [DATA_W-1:0] od,
                       output logic sf);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      coef_we   = we;
      coef_bank = bank;
      coef_addr = addr;
      coef_data = cd;
      #1;
      acc  = iv & in_ready;
      ov   = out_valid;
      fire = out_valid & ordy;
      oa   = out_approx;
      od   = out_detail;
      sf   = sat_flag;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
   endtask

   task automatic feed(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                       output logic acc, output logic fire, output logic ov,
                       output logic [DATA_W-1:0] oa);
      logic [DATA_W-1:0] od;
      logic sf;
      step(iv, d, ordy, 1'b0, 1'b0, '0, '0, acc, fire, ov, oa, od, sf);
   endtask

   task automatic do_clr(input logic iv, input logic [DATA_W-1:0] d);
      @(negedge clk);
      clr      = 1'b1;
      in_valid = iv;
      in_data  = d;
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic write_coef(input logic bank, input logic [ADDR_W-1:0] addr, input logic [COEF_W-1:0] cd);
      logic acc, fire, ov, sf;
      logic [DATA_W-1:0] oa, od;
      step(1'b0, '0, out_ready, 1'b1, bank, addr, cd, acc, fire, ov, oa, od, sf);
      if (int'(addr) < TAPS) begin
         if (bank) m_hi[addr] = longint'($signed(cd));
         else      m_lo[addr] = longint'($signed(cd));
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      vectors++; if (out_approx !== '0) begin miscompares++; $display("FAIL reset_approx got %0d want 0", $signed(out_approx)); end
      vectors++; if (out_detail !== '0) begin miscompares++; $display("FAIL reset_detail got %0d want 0", $signed(out_detail)); end
      vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL reset_sat got %0b want 0", sat_flag); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      model_haar();
      model_clear();
   endtask

   task automatic test_haar_dc();
      logic acc, fire, ov;
      logic [DATA_W-1:0] oa;
      feed(1'b1, 32'd268435456, 1'b1, acc, fire, ov, oa);
      vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL dc_accept0 got %0b want 1", acc); end
      feed(1'b1, 32'd268435456, 1'b1, acc, fire, ov, oa);
      vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL dc_early_valid got %0b want 0", ov); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL dc_latency got %0b want 1", out_valid); end
      vectors++; if (out_approx !== 32'd379650048) begin miscompares++; $display("FAIL dc_approx got %0d want 379650048", $signed(out_approx)); end
      vectors++; if (out_detail !== 32'd0) begin miscompares++; $display("FAIL dc_detail got %0d want 0", $signed(out_detail)); end
      feed(1'b0, '0, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dc_drain got %0b want 0", out_valid); end
   endtask

   task automatic test_haar_step();
      logic acc, fire, ov;
      logic [DATA_W-1:0] oa;
      logic [DATA_W-1:0] neg;
      neg = -32'sd189825024;
      feed(1'b1, 32'd0, 1'b1, acc, fire, ov, oa);
      feed(1'b1, 32'd268435456, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_approx !== 32'd189825024) begin miscompares++; $display("FAIL step_up_approx got %0d want 189825024", $signed(out_approx)); end
      vectors++; if (out_detail !== 32'd189825024) begin miscompares++; $display("FAIL step_up_detail got %0d want 189825024", $signed(out_detail)); end
      feed(1'b1, 32'd268435456, 1'b1, acc, fire, ov, oa);
      vectors++; if (fire !== 1'b1) begin miscompares++; $display("FAIL step_fire got %0b want 1", fire); end
      feed(1'b1, 32'd0, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_approx !== 32'd189825024) begin miscompares++; $display("FAIL step_dn_approx got %0d want 189825024", $signed(out_approx)); end
      vectors++; if (out_detail !== neg) begin miscompares++; $display("FAIL step_dn_detail got %0d want %0d", $signed(out_detail), $signed(neg)); end
      feed(1'b0, '0, 1'b1, acc, fire, ov, oa);
   endtask

   task automatic test_saturation();
      logic acc, fire, ov;
      logic [DATA_W-1:0] oa;
      feed(1'b1, 32'h7FFF_FFFF, 1'b1, acc, fire, ov, oa);
      feed(1'b1, 32'h7FFF_FFFF, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_approx !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL satpos_approx got %h want 7fffffff", out_approx); end
      vectors++; if (out_detail !== 32'd0) begin miscompares++; $display("FAIL satpos_detail got %0d want 0", $signed(out_detail)); end
      vectors++; if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL satpos_flag got %0b want 1", sat_flag); end
      feed(1'b0, '0, 1'b1, acc, fire, ov, oa);
      vectors++; if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_sticky got %0b want 1", sat_flag); end
      do_clr(1'b0, '0);
      vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL clr_sat got %0b want 0", sat_flag); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL clr_in_ready got %0b want 1", in_ready); end
      feed(1'b1, 32'h8000_0000, 1'b1, acc, fire, ov, oa);
      feed(1'b1, 32'h8000_0000, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_approx !== 32'h8000_0000) begin miscompares++; $display("FAIL satneg_approx got %h want 80000000", out_approx); end
      vectors++; if (out_detail !== 32'd0) begin miscompares++; $display("FAIL satneg_detail got %0d want 0", $signed(out_detail)); end
      vectors++; if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL satneg_flag got %0b want 1", sat_flag); end
      feed(1'b0, '0, 1'b1, acc, fire, ov, oa);
      do_clr(1'b0, '0);
   endtask

   task automatic test_backpressure();
      logic acc, fire, ov;
      logic [DATA_W-1:0] oa;
      int n_acc, n_fire;
      do_clr(1'b0, '0);
      feed(1'b1, 32'd67108864, 1'b0, acc, fire, ov, oa);
      feed(1'b1, 32'd134217728, 1'b0, acc, fire, ov, oa);
      vectors++; if (out_approx !== 32'd142368768) begin miscompares++; $display("FAIL bp_p1_approx got %0d want 142368768", $signed(out_approx)); end
      feed(1'b1, 32'd201326592, 1'b0, acc, fire, ov, oa);
      vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL bp_s3_accept got %0b want 1", acc); end
      feed(1'b1, 32'd268435456, 1'b0, acc, fire, ov, oa);
      vectors++; if (acc !== 1'b0) begin miscompares++; $display("FAIL bp_s4_blocked got %0b want 0", acc); end
      vectors++; if (out_approx !== 32'd142368768 || out_detail !== 32'd47456256) begin miscompares++; $display("FAIL bp_hold got %0d/%0d want 142368768/47456256", $signed(out_approx), $signed(out_detail)); end
      feed(1'b1, 32'd268435456, 1'b1, acc, fire, ov, oa);
      vectors++; if (acc !== 1'b1 || fire !== 1'b1) begin miscompares++; $display("FAIL bp_release got acc %0b fire %0b want 1 1", acc, fire); end
      vectors++; if (oa !== 32'd142368768) begin miscompares++; $display("FAIL bp_p1_consumed got %0d want 142368768", $signed(oa)); end
      vectors++; if (out_valid !== 1'b1 || out_approx !== 32'd332193792) begin miscompares++; $display("FAIL bp_p2 got v%0b %0d want v1 332193792", out_valid, $signed(out_approx)); end
      vectors++; if (out_detail !== 32'd47456256) begin miscompares++; $display("FAIL bp_p2_detail got %0d want 47456256", $signed(out_detail)); end
      feed(1'b0, '0, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %0b want 0", out_valid); end
      n_acc = 0;
      n_fire = 0;
      for (int i = 0; i < 8; i++) begin
         feed(1'b1, DATA_W'(i * 1000), 1'b1, acc, fire, ov, oa);
         n_acc += int'(acc);
         n_fire += int'(fire);
      end
      vectors++; if (n_acc !== 8 || n_fire !== 3) begin miscompares++; $display("FAIL bp_stream got acc %0d fire %0d want 8 3", n_acc, n_fire); end
      feed(1'b0, '0, 1'b1, acc, fire, ov, oa);
      do_clr(1'b0, '0);
   endtask

   task automatic test_clr_mid();
      logic acc, fire, ov;
      logic [DATA_W-1:0] oa;
      feed(1'b1, 32'd12345678, 1'b1, acc, fire, ov, oa);
      do_clr(1'b1, 32'h1000_0000);
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL clrmid_state got rdy %0b v %0b want 1 0", in_ready, out_valid); end
      feed(1'b1, 32'd268435456, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clrmid_phase got %0b want 0", out_valid); end
      feed(1'b1, 32'd268435456, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_approx !== 32'd379650048 || out_detail !== 32'd0) begin miscompares++; $display("FAIL clrmid_pair got %0d/%0d want 379650048/0", $signed(out_approx), $signed(out_detail)); end
      feed(1'b0, '0, 1'b1, acc, fire, ov, oa);
   endtask

   task automatic test_reprogram();
      logic acc, fire, ov;
      logic [DATA_W-1:0] oa;
      for (int k = 0; k < 4; k++) write_coef(1'b0, ADDR_W'(k), 16'sd4096);
      write_coef(1'b1, 4'd0, 16'sd8192);
      write_coef(1'b1, 4'd1, 16'sd0);
      write_coef(1'b1, 4'd2, 16'sd0);
      write_coef(1'b1, 4'd3, -16'sd8192);
      write_coef(1'b0, 4'd5, 16'sd12345);
      do_clr(1'b0, '0);
      feed(1'b1, 32'd67108864, 1'b1, acc, fire, ov, oa);
      feed(1'b1, 32'd134217728, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_approx !== 32'd100663296) begin miscompares++; $display("FAIL prog_p1_approx got %0d want 100663296", $signed(out_approx)); end
      vectors++; if (out_detail !== 32'd134217728) begin miscompares++; $display("FAIL prog_p1_detail got %0d want 134217728", $signed(out_detail)); end
      feed(1'b1, 32'd201326592, 1'b1, acc, fire, ov, oa);
      feed(1'b1, 32'd268435456, 1'b1, acc, fire, ov, oa);
      vectors++; if (out_approx !== 32'd335544320) begin miscompares++; $display("FAIL prog_p2_approx got %0d want 335544320", $signed(out_approx)); end
      vectors++; if (out_detail !== 32'd201326592) begin miscompares++; $display("FAIL prog_p2_detail got %0d want 201326592", $signed(out_detail)); end
      feed(1'b0, '0, 1'b1, acc, fire, ov, oa);
   endtask

   task automatic test_random();
      logic acc, fire, ov, sf, iv, ordy, we, bank;
      logic [DATA_W-1:0] d, oa, od;
      logic [ADDR_W-1:0] addr;
      logic [COEF_W-1:0] cd;
      longint ea, ed;
      bit es;
      do_clr(1'b0, '0);
      model_clear();
      for (int i = 0; i < 700; i++) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         we   = ($urandom_range(0, 11) == 0);
         bank = 1'($urandom_range(0, 1));
         addr = ADDR_W'($urandom_range(0, 15));
         cd   = COEF_W'($urandom);
         if ($urandom_range(0, 3) == 0) d = $urandom;
         else d = DATA_W'($urandom_range(0, 32'h2000_0000)) - 32'h1000_0000;
         step(iv, d, ordy, we, bank, addr, cd, acc, fire, ov, oa, od, sf);
         if (fire) begin
            if (exp_a.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL rnd_unexpected got output %0d want none", $signed(oa));
            end else begin
               ea = exp_a.pop_front();
               ed = exp_d.pop_front();
               es = exp_s.pop_front();
               vectors++; if (oa !== ea[DATA_W-1:0]) begin miscompares++; $display("FAIL rnd_approx got %0d want %0d", $signed(oa), ea); end
               vectors++; if (od !== ed[DATA_W-1:0]) begin miscompares++; $display("FAIL rnd_detail got %0d want %0d", $signed(od), ed); end
               vectors++; if (sf !== es) begin miscompares++; $display("FAIL rnd_sat got %0b want %0b", sf, es); end
            end
         end
         if (acc) model_accept(d);
         if (we && int'(addr) < TAPS) begin
            if (bank) m_hi[addr] = longint'($signed(cd));
            else      m_lo[addr] = longint'($signed(cd));
         end
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, acc, fire, ov, oa, od, sf);
         if (fire && exp_a.size() != 0) begin
            ea = exp_a.pop_front();
            ed = exp_d.pop_front();
            es = exp_s.pop_front();
            vectors++; if (oa !== ea[DATA_W-1:0] || od !== ed[DATA_W-1:0]) begin miscompares++; $display("FAIL rnd_tail got %0d/%0d want %0d/%0d", $signed(oa), $signed(od), ea, ed); end
         end
      end
      vectors++; if (exp_a.size() != 0) begin miscompares++; $display("FAIL rnd_missing got %0d pending want 0", exp_a.size()); end
   endtask

   task automatic test_reset_mid();
      logic acc, fire, ov;
      logic [DATA_W-1:0] oa;
      feed(1'b1, 32'd300000000, 1'b0, acc, fire, ov, oa);
      feed(1'b1, 32'd100000000, 1'b0, acc, fire, ov, oa);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got %0b want 1", out_valid); end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0 || out_approx !== '0 || out_detail !== '0) begin miscompares++; $display("FAIL rstmid_out got v%0b %0d/%0d want v0 0/0", out_valid, $signed(out_approx), $signed(out_detail)); end
      vectors++; if (sat_flag !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_flags got sat %0b rdy %0b want 0 1", sat_flag, in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      model_haar();
      model_clear();
   endtask

   initial begin
      test_reset();
      test_haar_dc();
      test_haar_step();
      test_saturation();
      test_backpressure();
      test_clr_mid();
      test_reprogram();
      test_random();
      test_reset_mid();
      test_haar_dc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
